// File: rtl/wb_burst_master.sv
// Wishbone initiator: turns command/stream requests into classic single or incrementing-burst
// cycles, supervises each beat with an ack timeout and returns read data as a valid-only stream.
module wb_burst_master #(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_resetn,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [3:0]      cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_sel,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int          SW       = DW / 8;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] { S_IDLE, S_XFER, S_END } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      rem_q, rem_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            rd_valid_q;
  logic [DW-1:0]   rd_data_q;

  logic            xfer;
  logic            stb;
  logic            ack_c;
  logic            last_beat;

  assign xfer      = (state_q == S_XFER);
  assign stb       = xfer & (~we_q | wr_valid);
  // An ack only counts while our strobe is up; stray acks are ignored.
  assign ack_c     = stb & wb_ack_i;
  assign last_beat = (rem_q == 4'd0);

  // Qualified with reset so the handshake is forced low while reset is held.
  assign cmd_ready = wb_resetn & sdr_init_done & (state_q == S_IDLE);
  assign wr_ready  = ack_c & we_q;

  assign wb_cyc_o  = xfer;
  assign wb_stb_o  = stb;
  assign wb_we_o   = xfer & we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = (xfer & we_q) ? wr_data : '0;
  assign wb_sel_o  = !xfer ? '0 : (we_q ? wr_sel : {SW{1'b1}});
  assign wb_cti_o  = (!xfer || len_q == 4'd0) ? 3'b000 :
                     (last_beat ? 3'b111 : 3'b010);

  assign done      = (state_q == S_END);
  assign err       = done & err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          rem_d   = cmd_len;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // A beat acked on the timeout cycle still completes normally.
        if (ack_c) begin
          addr_d = addr_q + AW'(SW);
          tmo_d  = '0;
          if (last_beat) begin
            err_d   = 1'b0;
            state_d = S_END;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_END;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_END: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= ack_c & ~we_q;
      if (ack_c && !we_q) rd_data_q <= wb_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed vector table, reset/init sequences and random bursts
// checked against a transaction-level model with a byte-addressed memory.
`timescale 1ns/1ps
module tb_wb_burst_master;

  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          wb_resetn;
  logic          sdr_init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_sel;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  always #5 clk = ~clk;

  wb_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_resetn(wb_resetn), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    int            len;
    int            wait_st;
    int            gap_beat;
    int            gap_len;
    bit            noack;
    int            ack_at;
    int            init_wait;
    int            exp_beats;
    bit            exp_err;
    int            exp_cyc;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 64'({cmd_ready, wr_ready, rd_valid, done, err,
                            wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o}), 64'(0));
    chk({tag, "_addr"}, 64'(wb_addr_o), 64'(0));
    chk({tag, "_dat"}, 64'(wb_dat_o), 64'(0));
    chk({tag, "_rdata"}, 64'(rd_data), 64'(0));
  endtask

  function automatic vec_t mk(bit we, logic [AW-1:0] a, int len, int ws, int gb, int gl,
                              bit na, int aa, int iw, int eb, bit ee, int ec);
    vec_t v;
    v.we = we; v.addr = a; v.len = len; v.wait_st = ws; v.gap_beat = gb; v.gap_len = gl;
    v.noack = na; v.ack_at = aa; v.init_wait = iw;
    v.exp_beats = eb; v.exp_err = ee; v.exp_cyc = ec;
    return v;
  endfunction

  // One whole transaction: command issue, slave model, write source, result checks.
  task automatic run_vec(input vec_t v, input string tag);
    logic [DW-1:0] wdat [16];
    logic [3:0]    wsel [16];
    logic [DW-1:0] exp_rd [$];
    logic [AW-1:0] ea;
    logic [DW-1:0] m;
    logic [2:0]    ecti;
    int beat = 0, cyc_n = 0, wcnt = 0, gap_left = v.gap_len;
    int dones = 0, errs = 0, rdv = 0, wrr = 0, bad_stb = 0, bad_rdy = 0;
    bit ack;
    bit fin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wdat[i] = $urandom;
      wsel[i] = 4'($urandom_range(1, 15));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_len = 4'(v.len);
    for (int w = 0; w < v.init_wait; w++) begin
      sdr_init_done = 1'b0;
      @(negedge clk);
      chk({tag, "_gate_rdy"}, 64'(cmd_ready), 64'(0));
      chk({tag, "_gate_cyc"}, 64'(wb_cyc_o), 64'(0));
      @(posedge clk); #1;
    end
    sdr_init_done = 1'b1;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int it = 1; it <= 300 && !fin; it++) begin
      wr_valid = v.we && beat <= v.len && !(beat == v.gap_beat && gap_left > 0);
      wr_data  = wdat[beat % 16];
      wr_sel   = wsel[beat % 16];
      sdr_init_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      ack = 1'b0;
      if (it == 1) chk({tag, "_cyc_after_accept"}, 64'(wb_cyc_o), 64'(1));
      if (wb_cyc_o) begin
        cyc_n++;
        if (cmd_ready) bad_rdy++;
        if (wb_stb_o !== (v.we ? wr_valid : 1'b1)) bad_stb++;
        if (v.we && beat == v.gap_beat && gap_left > 0) gap_left--;
        if (wb_stb_o) begin
          if (v.noack) ack = 1'b0;
          else if (v.ack_at > 0) ack = (cyc_n == v.ack_at);
          else if (wcnt >= v.wait_st) ack = 1'b1;
          else wcnt++;
        end
      end
      if (ack) begin
        ea   = v.addr + AW'(4 * beat);
        ecti = (v.len == 0) ? 3'b000 : ((beat == v.len) ? 3'b111 : 3'b010);
        chk($sformatf("%s_addr%0d", tag, beat), 64'(wb_addr_o), 64'(ea));
        chk($sformatf("%s_cti%0d", tag, beat), 64'(wb_cti_o), 64'(ecti));
        chk($sformatf("%s_we%0d", tag, beat), 64'(wb_we_o), 64'(v.we));
        m = mem.exists(ea) ? mem[ea] : $urandom;
        if (v.we) begin
          chk($sformatf("%s_dat%0d", tag, beat), 64'(wb_dat_o), 64'(wdat[beat]));
          chk($sformatf("%s_sel%0d", tag, beat), 64'(wb_sel_o), 64'(wsel[beat]));
          for (int b = 0; b < 4; b++)
            if (wsel[beat][b]) m[8*b +: 8] = wdat[beat][8*b +: 8];
          mem[ea] = m;
        end else begin
          chk($sformatf("%s_sel%0d", tag, beat), 64'(wb_sel_o), 64'(4'hF));
          mem[ea]  = m;
          wb_dat_i = m;
          exp_rd.push_back(m);
        end
        beat++;
        wcnt = 0;
      end else begin
        wb_dat_i = $urandom;
      end
      wb_ack_i = ack;
      #2;
      if (wr_ready) wrr++;
      if (rd_valid) begin
        rdv++;
        if (exp_rd.size() > 0) chk($sformatf("%s_rdata%0d", tag, rdv), 64'(rd_data), 64'(exp_rd.pop_front()));
      end
      if (err) errs++;
      if (done) begin
        dones++;
        fin = 1'b1;
        chk({tag, "_done_cyc_low"}, 64'(wb_cyc_o), 64'(0));
        chk({tag, "_done_timing"}, 64'(it), 64'(cyc_n + 1));
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    wb_ack_i = 1'b0;
    sdr_init_done = 1'b1;
    chk({tag, "_done_seen"}, 64'(fin), 64'(1));
    chk({tag, "_done_cnt"}, 64'(dones), 64'(1));
    chk({tag, "_beats"}, 64'(beat), 64'(v.exp_beats));
    chk({tag, "_err"}, 64'(errs), 64'(v.exp_err));
    chk({tag, "_cyc_len"}, 64'(cyc_n), 64'(v.exp_cyc));
    chk({tag, "_wr_ready_cnt"}, 64'(wrr), 64'(v.we ? v.exp_beats : 0));
    chk({tag, "_rd_valid_cnt"}, 64'(rdv), 64'(v.we ? 0 : v.exp_beats));
    chk({tag, "_stb_rule"}, 64'(bad_stb), 64'(0));
    chk({tag, "_busy_rdy"}, 64'(bad_rdy), 64'(0));
  endtask

  initial begin
    vec_t tbl [12];
    vec_t rv;
    logic [AW-1:0] ra;

    tbl[0]  = mk(1'b0, 26'h0000100,  0, 2, -1, 0, 1'b0, 0, 0,  1, 1'b0,   3);
    tbl[1]  = mk(1'b1, 26'h0000200,  3, 0, -1, 0, 1'b0, 0, 0,  4, 1'b0,   4);
    tbl[2]  = mk(1'b1, 26'h0000300,  3, 0,  2, 3, 1'b0, 0, 0,  4, 1'b0,   7);
    tbl[3]  = mk(1'b0, 26'h0000400,  0, 0, -1, 0, 1'b1, 0, 0,  0, 1'b1,   8);
    tbl[4]  = mk(1'b0, 26'h0000500,  0, 0, -1, 0, 1'b0, 8, 0,  1, 1'b0,   8);
    tbl[5]  = mk(1'b0, 26'h0000504,  0, 0, -1, 0, 1'b0, 9, 0,  0, 1'b1,   8);
    tbl[6]  = mk(1'b0, 26'h3FFFFFC,  1, 0, -1, 0, 1'b0, 0, 0,  2, 1'b0,   2);
    tbl[7]  = mk(1'b1, 26'h0000600,  3, 0,  1, 9, 1'b0, 0, 0,  1, 1'b1,   9);
    tbl[8]  = mk(1'b0, 26'h0000700, 15, 7, -1, 0, 1'b0, 0, 0, 16, 1'b0, 128);
    tbl[9]  = mk(1'b0, 26'h0000800,  0, 0, -1, 0, 1'b0, 0, 4,  1, 1'b0,   1);
    tbl[10] = mk(1'b1, 26'h0000100,  0, 1, -1, 0, 1'b0, 0, 0,  1, 1'b0,   2);
    tbl[11] = mk(1'b0, 26'h0000200,  3, 0, -1, 0, 1'b0, 0, 0,  4, 1'b0,   4);

    wb_resetn = 1'b0; sdr_init_done = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = 26'h0000040; cmd_len = 4'd3; wr_valid = 1'b1; wr_data = '1; wr_sel = 4'hF;
    wb_ack_i = 1'b0; wb_dat_i = '0;
    #1 chk_reset("rst0");
    repeat (2) @(posedge clk);
    #1;
    wb_resetn = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of a read burst.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h0000900; cmd_len = 4'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      wb_dat_i = $urandom;
      wb_ack_i = 1'b1;
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
    end
    chk("mid_cyc", 64'(wb_cyc_o), 64'(1));
    chk("mid_addr", 64'(wb_addr_o), 64'(26'h0000908));
    chk("mid_rd_valid", 64'(rd_valid), 64'(1));
    #2 wb_resetn = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    wb_resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));
    chk("post_rst_idle", 64'({wb_cyc_o, done, err}), 64'(0));

    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) ra = ra | 26'h3FFFF00;
      rv = mk(1'($urandom_range(0, 1)), ra, $urandom_range(0, 15), $urandom_range(0, 3),
              -1, 0, 1'b0, 0, $urandom_range(0, 1), 0, 1'b0, 0);
      if (rv.we) begin
        rv.gap_beat = $urandom_range(0, rv.len);
        rv.gap_len  = $urandom_range(0, 3);
      end
      rv.exp_beats = rv.len + 1;
      rv.exp_cyc   = (rv.len + 1) * (rv.wait_st + 1) + rv.gap_len;
      run_vec(rv, $sformatf("r%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
